bit_serializer: RTL

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `out_bit`, which drives the detector's serial `in` port directly. It also provides an `out_valid` qualifier, optional idle gap cycles between words, and a stall input. Detectors that lack a valid input see a clean stream of 0s whenever no word is in flight.

---
 rtl/serial_pkg.sv | 14 +
 rtl/bit_serializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the pattern-detector FSMs.
// Holds the state encoding and the default word width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int GAP_CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes WIDTH-bit words over valid/ready and emits
// one bit per clock, with optional idle gap cycles between words and a stall input.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t               state, state_next;
    logic [WIDTH-1:0]     shreg, shreg_next;
    logic [CW-1:0]        bit_cnt, bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_next;

    logic head;
    logic last_bit;
    logic accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    assign head     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign last_bit = (state == S_SHIFT) && (bit_cnt == '0);

    // With no gap configured the last-bit cycle doubles as a handshake slot,
    // which is what gives gapless back-to-back words.
    assign in_ready  = !stall && ((state == S_IDLE) || ((GAP == 0) && last_bit));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_SHIFT) && !stall;
    assign out_bit   = out_valid && head;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_next   = S_SHIFT;
                        shreg_next   = in_data;
                        bit_cnt_next = CW'(WIDTH - 1);
                    end
                end
                S_SHIFT: begin
                    if (MSB_FIRST != 0) begin
                        shreg_next = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_next = {1'b0, shreg[WIDTH-1:1]};
                    end
                    if (bit_cnt != '0) begin
                        bit_cnt_next = bit_cnt - CW'(1);
                    end else if (GAP != 0) begin
                        state_next   = S_GAP;
                        gap_cnt_next = GAP_CNT_W'(GAP - 1);
                    end else if (accept) begin
                        shreg_next   = in_data;
                        bit_cnt_next = CW'(WIDTH - 1);
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule
